rgb_fade_sequencer: RTL and testbench
=====================================

// Module: rgb_fade_sequencer
// PURPOSE
//  Drives the 8-bit red/green/blue setpoints of the RGB PWM stage from a small palette.
//  Steps through the palette entries in order: fades linearly from the current colour to each entry, then holds it.
//  Outputs change only on PWM-frame boundaries, so a PWM period never sees a mid-period setpoint change.
//  Sits between the host config interface and the PWM comparator.
// PARAMETERS
//  NUM_COLORS    8    palette depth (>=2); AW = $clog2(NUM_COLORS)
//  FRAME_CYCLES  256  clk cycles per PWM frame; matches the 8-bit PWM sawtooth
//  HOLD_FRAMES   64   frames the target colour is held before advancing (>=1)
//  STEP          1    max per-channel change per frame, 1..255
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      1-cycle pulse; begins sequence at entry 0 (only when idle)
//  stop       in   1      1-cycle pulse; abort to idle, outputs freeze
//  loop       in   1      1: wrap to entry 0 after last entry; 0: finish
//  seq_len    in   AW+1   active entries 1..NUM_COLORS, sampled at start
//  cfg_we     in   1      palette write strobe
//  cfg_addr   in   AW     palette index
//  cfg_rgb    in   24     {R[23:16],G[15:8],B[7:0]}
//  red        out  8      red setpoint to PWM
//  green      out  8      green setpoint to PWM
//  blue       out  8      blue setpoint to PWM
//  frame_tick out  1      1-cycle pulse on last cycle of each frame
//  busy       out  1      high in FADE/HOLD
//  idx        out  AW     palette entry currently targeted
//  done       out  1      1-cycle pulse when non-loop sequence ends
// BEHAVIOUR
//  Reset (async, any time): state IDLE, frame counter 0, idx 0, hold count 0, palette 0.
//   Also: red/green/blue 0, busy/done/frame_tick 0.
//  Frame counter: free-runs 0..FRAME_CYCLES-1 in all states; frame_tick = (cnt==FRAME_CYCLES-1).
//  FSM IDLE -> FADE: on start, when seq_len!=0 and stop=0.
//   Latch len = min(seq_len, NUM_COLORS), idx=0, target=palette[0]; busy rises next cycle.
//  FADE: on each frame_tick, per channel lvl moves toward target by min(STEP,|target-lvl|).
//   Unsigned 8-bit arithmetic; never overshoots, never wraps.
//   On the frame_tick where all three channels equal target -> HOLD, hold count cleared.
//   If lvl==target already at entry, -> HOLD on the next frame_tick.
//  HOLD: count frame_ticks; on the HOLD_FRAMES-th, if idx<len-1 then idx++, latch target, -> FADE.
//   Else if loop: idx=0, latch palette[0], -> FADE.
//   Else: done pulses 1 cycle, -> IDLE.
//  stop (any state) -> IDLE next cycle; lvl/outputs hold current values; no done pulse.
//  start+stop in the same cycle: stop wins. start while busy is ignored.
//  Palette writes are accepted every cycle, in any state.
//   Target is latched at entry load; a write to the active entry affects only its next load.
//  Outputs are registered; a new level is visible on the cycle after frame_tick (latency 1).
// CONFIGURATION
//  RGB_FADE_SEQUENCER_GAMMA_EN defined: out = (lvl*lvl)>>8, except lvl==255 -> 255.
//   Computed from the same register, same latency.
//  Not defined: out = lvl (linear).
// STRUCTURE
//  Package rgb_seq_pkg: RGB_W=8; typedef rgb_t {r,g,b}.
//   Also: state enum {IDLE,FADE,HOLD}; gamma function.
//  Sub-module rgb_channel_ramp: one 8-bit channel (lvl reg, step toward target, at_target flag).
//   Instantiated 3x.
// TESTING  (bench params FRAME_CYCLES=4, HOLD_FRAMES=2, STEP=16, NUM_COLORS=4)
//  1 Assert rst_n low -> all outputs 0, busy 0; frame_tick first pulses 4 cycles after release.
//  2 pal[0]=FF0000, seq_len=1, loop=0, start -> red 16,32..240,255 on 16 frame boundaries.
//    Then 2 hold frames, done 1 cycle, busy 0, red stays 255.
//  3 pal[0]=000080, pal[1]=00FF00, seq_len=2, loop=1 -> idx 0,1,0 cycles with no done.
//    blue ramps 0->128 in 8 frames, then green 0->255 while blue falls to 0.
//  4 stop during FADE at red=64 -> busy 0 next cycle; red holds 64 indefinitely.
//  5 start+stop same cycle -> stays IDLE; start with seq_len=0 -> ignored.
//    seq_len=7 -> clamped to 4.
//  6 cfg write to pal[idx] mid-FADE -> current ramp unchanged; new value used on next wrap.
//    Async rst_n low mid-HOLD -> outputs 0 without waiting for a clk edge.
//  GAMMA_EN build: lvl 128 -> out 64, lvl 255 -> out 255.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// ============================================================================
// Module : rgb_seq_pkg
// Brief  : Shared types for the RGB fade sequencer: colour struct, FSM states,
//          8-bit gamma approximation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rgb_seq_pkg;

    localparam int RGB_W = 8;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FADE = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Squared-level curve; full scale is pinned so 255 still means fully on.
    function automatic logic [RGB_W-1:0] gamma8(input logic [RGB_W-1:0] v);
        logic [2*RGB_W-1:0] sq;
        sq = 16'(v) * 16'(v);
        return (v == 8'hFF) ? 8'hFF : sq[2*RGB_W-1:RGB_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_fade_sequencer_ramp.sv
// ============================================================================
// Module : rgb_channel_ramp
// Brief  : One 8-bit colour channel: level register that steps toward a
//          target by at most STEP per enabled cycle, without overshoot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_channel_ramp
    import rgb_seq_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_en,
    input  logic [RGB_W-1:0] target,
    output logic [RGB_W-1:0] lvl,
    output logic             at_target
);

    localparam logic [RGB_W-1:0] c_step = RGB_W'(STEP);

    logic [RGB_W-1:0] r_lvl;
    logic [RGB_W-1:0] w_diff;
    logic [RGB_W-1:0] w_nxt;
    logic             w_up;

    always_comb begin
        w_up   = (target > r_lvl);
        w_diff = w_up ? (target - r_lvl) : (r_lvl - target);
        w_nxt  = target;
        if (w_diff > c_step) begin
            w_nxt = w_up ? (r_lvl + c_step) : (r_lvl - c_step);
        end
    end

    // High when the next step lands exactly on the target.
    assign at_target = (w_nxt == target);
    assign lvl       = r_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl <= '0;
        end else if (step_en) begin
            r_lvl <= w_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rgb_fade_sequencer.sv
// ============================================================================
// Module : rgb_fade_sequencer
// Brief  : Palette-driven RGB setpoint sequencer; fades to each entry, holds
//          it, and only updates levels on PWM frame boundaries.
//          Optional macro RGB_FADE_SEQUENCER_GAMMA_EN selects squared outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_fade_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int NUM_COLORS   = 8,
    parameter int FRAME_CYCLES = 256,
    parameter int HOLD_FRAMES  = 64,
    parameter int STEP         = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          loop,
    input  logic [$clog2(NUM_COLORS):0]   seq_len,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_COLORS)-1:0] cfg_addr,
    input  logic [23:0]                   cfg_rgb,
    output logic [RGB_W-1:0]              red,
    output logic [RGB_W-1:0]              green,
    output logic [RGB_W-1:0]              blue,
    output logic                          frame_tick,
    output logic                          busy,
    output logic [$clog2(NUM_COLORS)-1:0] idx,
    output logic                          done
);

    localparam int AW = $clog2(NUM_COLORS);
    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [CW-1:0] c_cnt_last  = CW'(FRAME_CYCLES - 1);
    localparam logic [HW-1:0] c_hold_last = HW'(HOLD_FRAMES - 1);
    localparam logic [AW:0]   c_num       = (AW+1)'(NUM_COLORS);

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt;
    rgb_t             r_pal [NUM_COLORS];
    rgb_t             r_tgt, w_tgt_nxt;
    logic [AW-1:0]    r_idx, w_idx_nxt, w_idx_inc;
    logic [AW:0]      r_len, w_len_nxt;
    logic [HW-1:0]    r_hold, w_hold_nxt;
    logic             r_done, w_done_nxt;
    logic             w_tick, w_step, w_more, w_all_at;
    logic [RGB_W-1:0] w_lvl_r, w_lvl_g, w_lvl_b;
    logic             w_at_r, w_at_g, w_at_b;

    assign w_tick    = (r_cnt == c_cnt_last);
    assign w_step    = (r_state == FADE) && w_tick && !stop;
    assign w_all_at  = w_at_r && w_at_g && w_at_b;
    assign w_idx_inc = r_idx + AW'(1);
    assign w_more    = (({1'b0, r_idx} + (AW+1)'(1)) < r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
                r_pal[i] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < c_num)) begin
            r_pal[cfg_addr] <= rgb_t'(cfg_rgb);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_hold  <= '0;
            r_tgt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_hold  <= w_hold_nxt;
            r_tgt   <= w_tgt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_hold_nxt  = r_hold;
        w_tgt_nxt   = r_tgt;
        w_done_nxt  = 1'b0;
        if (stop) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && (seq_len != '0)) begin
                        w_len_nxt   = (seq_len > c_num) ? c_num : seq_len;
                        w_idx_nxt   = '0;
                        w_tgt_nxt   = r_pal[0];
                        w_state_nxt = FADE;
                    end
                end
                FADE: begin
                    if (w_tick && w_all_at) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        if (r_hold != c_hold_last) begin
                            w_hold_nxt = r_hold + HW'(1);
                        end else if (w_more) begin
                            w_idx_nxt   = w_idx_inc;
                            w_tgt_nxt   = r_pal[w_idx_inc];
                            w_state_nxt = FADE;
                        end else if (loop) begin
                            w_idx_nxt   = '0;
                            w_tgt_nxt   = r_pal[0];
                            w_state_nxt = FADE;
                        end else begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    rgb_channel_ramp #(.STEP(STEP)) u_ramp_r (
        .clk(clk), .rst_n(rst_n), .step_en(w_step),
        .target(r_tgt.r), .lvl(w_lvl_r), .at_target(w_at_r)
    );
    rgb_channel_ramp #(.STEP(STEP)) u_ramp_g (
        .clk(clk), .rst_n(rst_n), .step_en(w_step),
        .target(r_tgt.g), .lvl(w_lvl_g), .at_target(w_at_g)
    );
    rgb_channel_ramp #(.STEP(STEP)) u_ramp_b (
        .clk(clk), .rst_n(rst_n), .step_en(w_step),
        .target(r_tgt.b), .lvl(w_lvl_b), .at_target(w_at_b)
    );

`ifdef RGB_FADE_SEQUENCER_GAMMA_EN
    assign red   = gamma8(w_lvl_r);
    assign green = gamma8(w_lvl_g);
    assign blue  = gamma8(w_lvl_b);
`else
    assign red   = w_lvl_r;
    assign green = w_lvl_g;
    assign blue  = w_lvl_b;
`endif

    assign frame_tick = w_tick;
    assign busy       = (r_state != IDLE);
    assign idx        = r_idx;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_rgb_fade_sequencer.sv
// ============================================================================
// Module : tb_rgb_fade_sequencer
// Brief  : Self-checking bench: directed scenarios plus random traffic, every
//          cycle compared against a frame-level behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rgb_fade_sequencer;

    localparam int NC = 4;
    localparam int FC = 4;
    localparam int HF = 2;
    localparam int ST = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [2:0]  seq_len = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [23:0] cfg_rgb = '0;
    logic [7:0]  red, green, blue;
    logic        frame_tick, busy, done;
    logic [1:0]  idx;

    int n_total = 0;
    int n_bad   = 0;

    rgb_fade_sequencer #(
        .NUM_COLORS(NC), .FRAME_CYCLES(FC), .HOLD_FRAMES(HF), .STEP(ST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
        .seq_len(seq_len), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_rgb(cfg_rgb),
        .red(red), .green(green), .blue(blue), .frame_tick(frame_tick),
        .busy(busy), .idx(idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: whole sequence described in terms of frames and entries.
    int          m_cnt, m_phase, m_idx, m_len, m_hold;
    int          m_lvl[3], m_tgt[3];
    logic [23:0] m_pal[NC];
    bit          m_done;

    function automatic int out8(input int v);
`ifdef RGB_FADE_SEQUENCER_GAMMA_EN
        if (v == 255) return 255;
        return (v * v) / 256;
`else
        return v;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_phase = 0; m_idx = 0; m_len = 0; m_hold = 0; m_done = 0;
        for (int c = 0; c < 3; c++) begin m_lvl[c] = 0; m_tgt[c] = 0; end
        for (int i = 0; i < NC; i++) m_pal[i] = '0;
    endtask

    task automatic model_load(input int e);
        logic [23:0] col;
        col = m_pal[e];
        m_tgt[0] = int'(col[23:16]);
        m_tgt[1] = int'(col[15:8]);
        m_tgt[2] = int'(col[7:0]);
    endtask

    task automatic model_step();
        bit tick, same;
        tick   = (m_cnt == FC - 1);
        m_done = 0;
        if (stop) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (start && seq_len != 0) begin
                m_len = (int'(seq_len) > NC) ? NC : int'(seq_len);
                m_idx = 0;
                model_load(0);
                m_phase = 1;
            end
        end else if (m_phase == 1 && tick) begin
            same = 1;
            for (int c = 0; c < 3; c++) begin
                if (m_tgt[c] - m_lvl[c] > ST)       m_lvl[c] += ST;
                else if (m_lvl[c] - m_tgt[c] > ST)  m_lvl[c] -= ST;
                else                                m_lvl[c] = m_tgt[c];
                if (m_lvl[c] != m_tgt[c]) same = 0;
            end
            if (same) begin m_phase = 2; m_hold = 0; end
        end else if (m_phase == 2 && tick) begin
            m_hold++;
            if (m_hold == HF) begin
                if (m_idx < m_len - 1) begin
                    m_idx++; model_load(m_idx); m_phase = 1;
                end else if (loop) begin
                    m_idx = 0; model_load(0); m_phase = 1;
                end else begin
                    m_done = 1; m_phase = 0;
                end
            end
        end
        if (cfg_we) m_pal[cfg_addr] = cfg_rgb;
        m_cnt = (m_cnt + 1) % FC;
    endtask

    task automatic compare_outs(input string tag);
        logic [28:0] exp;
        exp = {8'(out8(m_lvl[0])), 8'(out8(m_lvl[1])), 8'(out8(m_lvl[2])),
               (m_phase != 0), 2'(m_idx), m_done, (m_cnt == FC - 1)};
        check(tag, {35'd0, red, green, blue, busy, idx, done, frame_tick}, {35'd0, exp});
    endtask

    // One clock: inputs already driven; pulses are dropped after the cycle.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outs("outs");
        start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        compare_outs("reset_outs");
        check("reset_busy", busy, 0);
        rst_n = 1'b1;
    endtask

    task automatic pal_write(input int a, input logic [23:0] v);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_rgb = v;
        cycle();
    endtask

    task automatic begin_seq(input int len, input bit lp);
        seq_len = 3'(len); loop = lp; start = 1'b1;
        cycle();
    endtask

    initial begin
        int   k, ticks, tr, maxidx, ndone;
        bit   seen;
        logic [7:0] prev;
        logic [1:0] pidx;
        int   q[$];

        model_reset();
        repeat (2) @(negedge clk);

        // 1: reset values and frame counter start
        apply_reset();
        k = 0;
        for (int i = 1; i <= 8 && k == 0; i++) begin
            cycle();
            if (frame_tick) k = i;
        end
        check("first_tick", k, 3);

        // 2: single-entry ramp to full red, hold, done
        apply_reset();
        pal_write(0, 24'hFF0000);
        begin_seq(1, 0);
        prev = red; ticks = 0; seen = 0; q.delete();
        for (int i = 0; i < 200 && !seen; i++) begin
            if (frame_tick) ticks++;
            cycle();
            if (red != prev) begin q.push_back(int'(red)); prev = red; end
            if (done) seen = 1;
        end
        check("t2_done_seen", seen, 1);
        check("t2_frames", ticks, 18);
        check("t2_nsteps", q.size(), 16);
        for (int i = 0; i < q.size() && i < 16; i++)
            check("t2_step", q[i], out8((16 * (i + 1) > 255) ? 255 : 16 * (i + 1)));
        check("t2_busy", busy, 0);
        run(10);
        check("t2_red_kept", red, out8(255));

        // 3: two entries, looping
        apply_reset();
        pal_write(0, 24'h000080);
        pal_write(1, 24'h00FF00);
        begin_seq(2, 1);
        ndone = 0; tr = 0; pidx = idx;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (done) ndone++;
            if (idx != pidx) begin
                tr++;
                if (tr == 1) check("t3_blue_at_switch", blue, out8(128));
                if (tr == 2) check("t3_green_at_wrap", {green, blue}, {8'(out8(255)), 8'h00});
                pidx = idx;
            end
        end
        check("t3_no_done", ndone, 0);
        check("t3_idx_010", (tr >= 2), 1);
        check("t3_busy", busy, 1);
        stop = 1'b1; cycle();

        // 4: stop mid-fade freezes red at 64
        apply_reset();
        pal_write(0, 24'hFF0000);
        begin_seq(1, 0);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycle();
            if (red == 8'(out8(64))) seen = 1;
        end
        check("t4_reach64", seen, 1);
        stop = 1'b1; cycle();
        check("t4_busy_drop", busy, 0);
        run(40);
        check("t4_red_frozen", red, out8(64));

        // 5: start+stop, zero length, clamped length
        apply_reset();
        pal_write(0, 24'h102030);
        pal_write(1, 24'hF00F80);
        pal_write(2, 24'h00FFFF);
        pal_write(3, 24'h404040);
        seq_len = 3'd2; start = 1'b1; stop = 1'b1; cycle();
        check("t5_start_stop", busy, 0);
        run(3);
        begin_seq(0, 0);
        check("t5_len0", busy, 0);
        begin_seq(7, 0);
        seen = 0; maxidx = 0;
        for (int i = 0; i < 600 && !seen; i++) begin
            cycle();
            if (int'(idx) > maxidx) maxidx = int'(idx);
            if (done) seen = 1;
        end
        check("t5_done", seen, 1);
        check("t5_maxidx", maxidx, 3);

        // 6: palette write to the active entry, then async reset in HOLD
        apply_reset();
        pal_write(0, 24'hFF0000);
        begin_seq(1, 1);
        run(20);
        pal_write(0, 24'h00FF00);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle();
            if (red == 8'(out8(255))) seen = 1;
        end
        check("t6_old_target", {seen, green}, {1'b1, 8'h00});
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            cycle();
            if (green == 8'(out8(255))) seen = 1;
        end
        check("t6_new_target", {seen, red}, {1'b1, 8'h00});
        #2 rst_n = 1'b0;
        #1 check("t6_async_rst", {red, green, blue, busy, idx}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            loop     = 1'($urandom_range(0, 1));
            seq_len  = 3'($urandom_range(0, 7));
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_rgb  = 24'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
